serial_tx: RTL and testbench

Framed serial transmitter that converts a parallel byte into a bit-serial line: one start bit, DATA_W data bits LSB first, an optional even-parity bit, and one stop bit. Each bit is held for a fixed number of clock cycles. It drives the line that a flip-flop-based serial receiver samples, and it sits between a parallel producer using a valid/ready handshake and the serial output pin.

---
 rtl/serial_tx.sv | 145 ++++++++++++++
 tb/tb_serial_tx.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_tx.sv
// Framed serial transmitter: start bit, DATA_W data bits LSB first, optional
// even-parity bit, stop bit, each held CLKS_PER_BIT cycles. All outputs registered.
module serial_tx #(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned PARITY_EN    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              txd,
    output logic              busy,
    output logic              done
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              parity_q, parity_d;
    logic              txd_d, busy_d, ready_d, done_d;
    logic              bit_end;

    assign bit_end = (cnt_q == CNT_LAST);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // Next-state, datapath and next-output logic; outputs derive from the next state
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        parity_d = parity_q;
        done_d   = 1'b0;
        txd_d    = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (tx_valid) begin
                    shift_d  = tx_data;
                    parity_d = ^tx_data;
                    cnt_d    = '0;
                    bit_d    = '0;
                    state_d  = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == BIT_LAST) begin
                        bit_d   = '0;
                        state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                bit_d   = '0;
                state_d = S_IDLE;
            end
        endcase

        case (state_d)
            S_START:  txd_d = 1'b0;
            S_DATA:   txd_d = shift_d[0];
            S_PARITY: txd_d = parity_d;
            default:  txd_d = 1'b1;
        endcase

        ready_d = (state_d == S_IDLE);
        busy_d  = !ready_d;
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            txd      <= 1'b1;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            txd      <= txd_d;
            tx_ready <= ready_d;
            busy     <= busy_d;
            done     <= done_d;
        end
    end

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: three instances (default, no parity, one clock per bit)
// checked every cycle against a queue of expected line/status values.
module tb_serial_tx;

    localparam int unsigned NI = 3;
    localparam int unsigned CPB [NI] = '{4, 4, 1};
    localparam int unsigned PEN [NI] = '{1, 0, 1};

    typedef struct packed {
        logic txd;
        logic busy;
        logic done;
        logic ready;
    } exp_t;

    typedef struct {
        int         inst;
        logic [7:0] data;
        logic       par;
    } vec_t;

    localparam exp_t IDLE_EXP = '{txd: 1'b1, busy: 1'b0, done: 1'b0, ready: 1'b1};

    logic       clk;
    logic       rst;
    logic [7:0] tx_data  [NI];
    logic       tx_valid [NI];
    logic       tx_ready [NI];
    logic       txd      [NI];
    logic       busy     [NI];
    logic       done     [NI];

    exp_t exp_q [NI][$];
    int   checks;
    int   failures;

    serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1)) dut0 (
        .clk(clk), .rst(rst), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
        .tx_ready(tx_ready[0]), .txd(txd[0]), .busy(busy[0]), .done(done[0]));

    serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(0)) dut1 (
        .clk(clk), .rst(rst), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
        .tx_ready(tx_ready[1]), .txd(txd[1]), .busy(busy[1]), .done(done[1]));

    serial_tx #(.DATA_W(8), .CLKS_PER_BIT(1), .PARITY_EN(1)) dut2 (
        .clk(clk), .rst(rst), .tx_data(tx_data[2]), .tx_valid(tx_valid[2]),
        .tx_ready(tx_ready[2]), .txd(txd[2]), .busy(busy[2]), .done(done[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int flen(input int i);
        return (2 + 8 + int'(PEN[i])) * int'(CPB[i]);
    endfunction

    task automatic chk(input string name, input int i, input exp_t got, input exp_t want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s inst=%0d t=%0t txd/busy/done/ready got=%b required=%b",
                     name, i, $time, got, want);
        end
    endtask

    function automatic exp_t outs(input int i);
        return '{txd: txd[i], busy: busy[i], done: done[i], ready: tx_ready[i]};
    endfunction

    task automatic push_bit(input int i, input logic b);
        exp_t e;
        e = '{txd: b, busy: 1'b1, done: 1'b0, ready: 1'b0};
        for (int k = 0; k < int'(CPB[i]); k++) exp_q[i].push_back(e);
    endtask

    // Expected per-cycle outputs for one frame, starting the cycle after acceptance
    task automatic push_frame(input int i, input logic [7:0] d, input logic par);
        exp_t e;
        push_bit(i, 1'b0);
        for (int b = 0; b < 8; b++) push_bit(i, d[b]);
        if (PEN[i] != 0) push_bit(i, par);
        push_bit(i, 1'b1);
        e = '{txd: 1'b1, busy: 1'b0, done: 1'b1, ready: 1'b1};
        exp_q[i].push_back(e);
    endtask

    task automatic send(input int i, input logic [7:0] d, input logic par);
        @(negedge clk);
        tx_valid[i] = 1'b1;
        tx_data[i]  = d;
        @(posedge clk);
        push_frame(i, d, par);
        @(negedge clk);
        tx_valid[i] = 1'b0;
        tx_data[i]  = 8'($urandom);
        repeat (flen(i) + 2) @(posedge clk);
    endtask

    // Per-cycle monitor: an empty queue means the line must be idle
    always @(negedge clk) begin
        for (int i = 0; i < int'(NI); i++) begin
            exp_t e;
            if (exp_q[i].size() > 0) e = exp_q[i].pop_front();
            else                     e = IDLE_EXP;
            chk("cycle", i, outs(i), e);
        end
    end

    vec_t vecs [11];

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        for (int i = 0; i < int'(NI); i++) begin
            tx_valid[i] = 1'b0;
            tx_data[i]  = 8'h00;
        end

        vecs[0]  = '{0, 8'hA5, 1'b0};
        vecs[1]  = '{0, 8'h07, 1'b1};
        vecs[2]  = '{0, 8'h00, 1'b0};
        vecs[3]  = '{0, 8'hFF, 1'b0};
        vecs[4]  = '{0, 8'h01, 1'b1};
        vecs[5]  = '{0, 8'h80, 1'b1};
        vecs[6]  = '{1, 8'h07, 1'b1};
        vecs[7]  = '{1, 8'hA5, 1'b0};
        vecs[8]  = '{2, 8'hA5, 1'b0};
        vecs[9]  = '{2, 8'h6B, 1'b1};
        vecs[10] = '{2, 8'hFE, 1'b1};

        // Reset held with random inputs
        repeat (5) begin
            @(negedge clk);
            for (int i = 0; i < int'(NI); i++) begin
                tx_valid[i] = 1'($urandom);
                tx_data[i]  = 8'($urandom);
            end
            #1;
            for (int i = 0; i < int'(NI); i++) chk("reset_rand", i, outs(i), IDLE_EXP);
        end
        @(negedge clk);
        for (int i = 0; i < int'(NI); i++) tx_valid[i] = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);

        foreach (vecs[v]) send(vecs[v].inst, vecs[v].data, vecs[v].par);

        // Back-to-back with tx_valid held: next word taken in the done cycle
        @(negedge clk);
        tx_valid[0] = 1'b1;
        tx_data[0]  = 8'h3C;
        @(posedge clk);
        push_frame(0, 8'h3C, 1'b0);
        @(negedge clk);
        tx_data[0] = 8'hC3;
        repeat (44) @(posedge clk);
        @(posedge clk);
        push_frame(0, 8'hC3, 1'b0);
        @(negedge clk);
        tx_valid[0] = 1'b0;
        repeat (46) @(posedge clk);

        // Inputs changing during a frame must not disturb it
        @(negedge clk);
        tx_valid[0] = 1'b1;
        tx_data[0]  = 8'h55;
        @(posedge clk);
        push_frame(0, 8'h55, 1'b0);
        @(negedge clk);
        tx_data[0] = 8'hFF;
        repeat (44) @(posedge clk);
        @(negedge clk);
        tx_valid[0] = 1'b0;
        repeat (6) @(posedge clk);

        // Asynchronous reset in data bit 3 of 8'hF0
        @(negedge clk);
        tx_valid[0] = 1'b1;
        tx_data[0]  = 8'hF0;
        @(posedge clk);
        push_frame(0, 8'hF0, 1'b0);
        @(negedge clk);
        tx_valid[0] = 1'b0;
        repeat (17) @(posedge clk);
        #2;
        chk("pre_abort", 0, outs(0), '{txd: 1'b0, busy: 1'b1, done: 1'b0, ready: 1'b0});
        rst = 1'b0;
        for (int i = 0; i < int'(NI); i++) exp_q[i].delete();
        #1;
        chk("async_reset", 0, outs(0), IDLE_EXP);
        repeat (2) @(negedge clk);
        chk("reset_hold", 0, outs(0), IDLE_EXP);

        // tx_valid raised together with reset release
        @(negedge clk);
        rst         = 1'b1;
        tx_valid[0] = 1'b1;
        tx_data[0]  = 8'h81;
        @(posedge clk);
        push_frame(0, 8'h81, 1'b0);
        @(negedge clk);
        tx_valid[0] = 1'b0;
        repeat (48) @(posedge clk);

        @(negedge clk);
        #1;
        for (int i = 0; i < int'(NI); i++) begin
            checks++;
            if (exp_q[i].size() != 0) begin
                failures++;
                $display("FAIL drain inst=%0d leftover=%0d required=0", i, exp_q[i].size());
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
